// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow controller: state codes,
// winner codes and player index constants.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;

   localparam int PLAYER0 = 0;
   localparam int PLAYER1 = 1;

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// Serve-delay timer: counts frame ticks, wraps to zero on the terminal tick,
// and is held at zero by a synchronous clear while not serving.
module frame_timer #(
   parameter int SERVE_TICKS = 120
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic tc
);

   localparam int TW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

   logic [TW-1:0] cnt;

   assign tc = (cnt == TW'(SERVE_TICKS - 1));

   // Tick counter; the terminal tick returns it to zero for the next serve
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (tick)
         cnt <= tc ? '0 : cnt + TW'(1);
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM. Converts ball-miss events into registered one-cycle
// score-counter pulses, sequences serve/play/point/game-over and tracks
// per-player tallies to detect the winning score.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 120,
   parameter int PW          = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic [1:0] d_inc,
   output logic       d_clr,
   output logic       ball_en,
   output logic       ball_rst,
   output logic       serve_dir,
   output logic [2:0] state,
   output logic [1:0] winner
);

   localparam logic [PW-1:0] WIN = PW'(WIN_SCORE);

   state_t              state_q, state_d;
   logic                start_q;
   logic                start_rise;
   logic                serve_tc;
   logic [1:0][PW-1:0]  tally_q, tally_d;
   logic [1:0]          winner_q, winner_d;
   logic                serve_dir_q, serve_dir_d;
   logic [1:0]          d_inc_d;
   logic                d_clr_d, ball_rst_d;

   assign start_rise = start & ~start_q;
   assign state      = state_q;
   assign ball_en    = (state_q == PLAY);
   assign winner     = winner_q;
   assign serve_dir  = serve_dir_q;

   frame_timer #(.SERVE_TICKS(SERVE_TICKS)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != SERVE),
      .tick  (frame_tick),
      .tc    (serve_tc)
   );

   // Previous start level for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) start_q <= 1'b0;
      else       start_q <= start;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, tally/winner updates and the pulse values for next cycle
   always_comb begin
      state_d     = state_q;
      tally_d     = tally_q;
      winner_d    = winner_q;
      serve_dir_d = serve_dir_q;
      d_inc_d     = 2'b00;
      d_clr_d     = 1'b0;
      ball_rst_d  = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start_rise) begin
               state_d    = SERVE;
               d_clr_d    = 1'b1;
               ball_rst_d = 1'b1;
               tally_d    = '0;
               winner_d   = WIN_NONE;
            end
         end
         SERVE: begin
            if (frame_tick && serve_tc) state_d = PLAY;
         end
         PLAY: begin
            // A simultaneous double miss is a replayed serve: nobody scores
            if (miss_l && miss_r) begin
               state_d = POINT;
            end else if (miss_r) begin
               state_d          = POINT;
               d_inc_d[PLAYER0] = 1'b1;
               serve_dir_d      = 1'b1;
               if (tally_q[PLAYER0] < WIN)
                  tally_d[PLAYER0] = tally_q[PLAYER0] + PW'(1);
            end else if (miss_l) begin
               state_d          = POINT;
               d_inc_d[PLAYER1] = 1'b1;
               serve_dir_d      = 1'b0;
               if (tally_q[PLAYER1] < WIN)
                  tally_d[PLAYER1] = tally_q[PLAYER1] + PW'(1);
            end
         end
         POINT: begin
            if (tally_q[PLAYER0] == WIN) begin
               state_d  = OVER;
               winner_d = WIN_P0;
            end else if (tally_q[PLAYER1] == WIN) begin
               state_d  = OVER;
               winner_d = WIN_P1;
            end else begin
               state_d    = SERVE;
               ball_rst_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered tallies, winner, serve direction and one-cycle pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tally_q     <= '0;
         winner_q    <= WIN_NONE;
         serve_dir_q <= 1'b0;
         d_inc       <= 2'b00;
         d_clr       <= 1'b0;
         ball_rst    <= 1'b0;
      end else begin
         tally_q     <= tally_d;
         winner_q    <= winner_d;
         serve_dir_q <= serve_dir_d;
         d_inc       <= d_inc_d;
         d_clr       <= d_clr_d;
         ball_rst    <= ball_rst_d;
      end
   end

endmodule
